qspi_mem_target: RTL and testbench
==================================

# qspi_mem_target

Synthesizable quad-SPI memory responder: the device end of the link driven by the `qspi` cache-line controller. It decodes quad read and quad write transactions and serves them from an on-chip SRAM port. It is used on the FPGA/bring-up board in place of external flash/PSRAM, and as the memory model in system simulation. The QSPI clock is the system clock, so the block runs entirely in the `clk` domain.

## Interface

Parameters:
- `PA`, 24: address width carried on the wire, in bits.
- `MEM_AW`, 16: byte address width of the SRAM port. Wire addresses wrap modulo 2^MEM_AW.
- `DUMMY`, 4: dummy nibble cycles between address and read data. Must be ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, also the QSPI clock.
- `reset` in 1: synchronous, active-high.
- `cs_n` in 1: chip select, active low.
- `io_in` in 4: QSPI data from the controller.
- `io_out` out 4: QSPI data to the controller.
- `io_oe` out 1: output enable for `io_out`, active high.
- `mem_addr` out MEM_AW: SRAM byte address.
- `mem_re` out 1: SRAM read strobe. Data is returned the following cycle.
- `mem_rdata` in 8: SRAM read data.
- `mem_we` out 1: SRAM write strobe, one cycle.
- `mem_wdata` out 8: SRAM write data.

## Operation

- Commands:
  - `0xEB`: quad read.
  - `0x38`: quad write.
  - Any other value is ignored until `cs_n` rises.
- Frame format, all fields quad, high nibble first:
  - 2 command nibbles.
  - 6 address nibbles.
  - Read: DUMMY dummy nibbles, then data nibbles.
  - Write: data nibbles immediately after the address.
- States:
  - IDLE → CMD on the first sampled `cs_n`=0.
  - CMD → ADDR after 2 nibbles, if the command is valid; otherwise CMD → IGNORE.
  - ADDR → DUMMY (read) or WDATA (write) after 6 nibbles.
  - DUMMY → RDATA after DUMMY nibbles.
  - RDATA and WDATA stream data until chip select deasserts.
  - Any state → IDLE whenever `cs_n`=1 is sampled.
- Read path:
  - `mem_re` is asserted in the cycle after the last address nibble.
  - The returned byte is loaded into the shift register.
  - In RDATA, high nibble then low nibble are output per byte.
  - The next-byte read (address+1) is issued in the cycle that drives the high nibble, so streaming is seamless.
- Write path:
  - Nibble pairs are assembled into a byte.
  - `mem_we` pulses in the cycle after the low nibble is sampled, with `mem_addr` equal to the current address.
  - The address then increments.
  - A partial byte left when `cs_n` rises is discarded.
- Address arithmetic: the 24-bit wire address is truncated to `MEM_AW` bits. The increment wraps from 2^MEM_AW−1 to 0.
- Reset values: `io_oe`=0, `io_out`=0, `mem_re`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. State is IDLE.
- Reset mid-transaction: the block returns to IDLE immediately and any pending write is dropped. It does not respond until `cs_n` has been sampled high and then low again.

## Timing

- Cycle numbering: cycle 0 is the first rising edge at which `cs_n`=0 is sampled.
- Command nibbles are sampled at cycles 0–1.
- Address nibbles are sampled at cycles 2–7.
- `mem_re` is high during cycle 8; `mem_rdata` is valid in cycle 9.
- `io_oe` rises at the edge ending the last dummy cycle, i.e. edge 7+DUMMY.
- The first data nibble (high nibble of byte 0) is valid on `io_out` during cycle 8+DUMMY. Nibble n is valid during cycle 8+DUMMY+n.
- `io_out` and `io_oe` are registered.
- `cs_n` sampled high at edge k: `io_oe`=0 from cycle k+1. No `mem_re` or `mem_we` is issued after edge k.
- Write of byte m:
  - Its low nibble is sampled at edge 9+2m.
  - `mem_we` is high during cycle 10+2m.
- `cs_n` high for a single cycle between frames is sufficient. Back-to-back frames are supported.

## Structure

- A shared package `qspi_pkg` holds:
  - Command constants `QSPI_CMD_QREAD`=8'hEB and `QSPI_CMD_QWRITE`=8'h38.
  - The state enum.
  - Field lengths: CMD nibbles 2, ADDR nibbles 6.
- The `qspi` controller imports the same package.
- Single module with no sub-modules. The nibble shift register and the nibble counter are inline.

## Test plan

- Quad read, SRAM[0x0010..0x0013] = 11 22 33 44, address 0x000010, DUMMY=4 → `io_oe` rises at edge 11. Nibbles 1,1,2,2,3,3,4,4 appear on cycles 12–19. `mem_re` pulses at addresses 0x10, 0x11, 0x12, 0x13.
- Quad write 0x38, address 0x000100, data A5 5A → `mem_we` in cycle 10 with 0x0100/A5, and in cycle 12 with 0x0101/5A. `io_oe` stays 0 throughout.
- Wrap-around, MEM_AW=16: read at 0x00FFFF, 2 bytes → `mem_re` addresses 0xFFFF then 0x0000. Wire address 0x12FFFF maps to 0xFFFF.
- Invalid command 0x9F followed by 20 nibbles → no `mem_re`/`mem_we`, `io_oe`=0. A following valid read frame is served correctly.
- `cs_n` rises mid-write after 3 data nibbles → exactly one `mem_we` is issued. `cs_n` rises mid-read → `io_oe`=0 the next cycle.
- `reset` asserted during RDATA → all outputs are 0 the next cycle. No response until `cs_n` is sampled high and then low again.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared QSPI definitions used by the cache-line controller and the memory target.
// Holds command opcodes, frame field lengths and the target state encoding.
package qspi_pkg;

  localparam logic [7:0] QSPI_CMD_QREAD  = 8'hEB;
  localparam logic [7:0] QSPI_CMD_QWRITE = 8'h38;

  localparam int CMD_NIBBLES  = 2;
  localparam int ADDR_NIBBLES = 6;
  localparam int CNT_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } qspi_state_e;

endpackage

// File: rtl/qspi_mem_target.sv
// Quad-SPI memory responder: decodes quad read/write frames and serves them from an SRAM port.
// Runs on the system clock, which doubles as the QSPI clock.
module qspi_mem_target
  import qspi_pkg::*;
#(
  parameter int PA     = 24,
  parameter int MEM_AW = 16,
  parameter int DUMMY  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic              io_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata
);

  qspi_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PA-5:0]     sh_q, sh_d;
  logic              is_rd_q, is_rd_d;
  logic              armed_q, armed_d;
  logic              re_dly_q;
  logic [7:0]        buf_q, buf_d;
  logic [3:0]        io_out_q, io_out_d;
  logic              io_oe_q, io_oe_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;

  logic [PA-5:0]     sh_shift;
  logic [7:0]        byte_src;
  logic [7:0]        cmd_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      is_rd_q  <= 1'b0;
      armed_q  <= 1'b0;
      re_dly_q <= 1'b0;
      buf_q    <= '0;
      io_out_q <= '0;
      io_oe_q  <= 1'b0;
      addr_q   <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      is_rd_q  <= is_rd_d;
      armed_q  <= armed_d;
      re_dly_q <= re_q;
      buf_q    <= buf_d;
      io_out_q <= io_out_d;
      io_oe_q  <= io_oe_d;
      addr_q   <= addr_d;
      re_q     <= re_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  assign sh_shift = {sh_q[PA-9:0], io_in};
  assign cmd_byte = {sh_q[3:0], io_in};
  // SRAM data is only valid the cycle after a read strobe; afterwards it lives in buf_q.
  assign byte_src = re_dly_q ? mem_rdata : buf_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    is_rd_d  = is_rd_q;
    armed_d  = armed_q;
    buf_d    = byte_src;
    io_out_d = io_out_q;
    io_oe_d  = io_oe_q;
    addr_d   = addr_q;
    re_d     = 1'b0;
    we_d     = 1'b0;
    wdata_d  = wdata_q;

    if (cs_n) begin
      state_d  = ST_IDLE;
      armed_d  = 1'b1;
      cnt_d    = '0;
      io_oe_d  = 1'b0;
      io_out_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // armed_q stays low after reset until chip select has been seen high.
          if (armed_q) begin
            state_d = ST_CMD;
            sh_d    = sh_shift;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_CMD: begin
          sh_d  = sh_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CMD_NIBBLES - 1)) begin
            cnt_d = '0;
            if (cmd_byte == QSPI_CMD_QREAD) begin
              state_d = ST_ADDR;
              is_rd_d = 1'b1;
            end else if (cmd_byte == QSPI_CMD_QWRITE) begin
              state_d = ST_ADDR;
              is_rd_d = 1'b0;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          sh_d  = sh_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_NIBBLES - 1)) begin
            cnt_d  = '0;
            addr_d = MEM_AW'({sh_q, io_in});
            if (is_rd_q) begin
              state_d = ST_DUMMY;
              re_d    = 1'b1;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_DUMMY: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DUMMY - 1)) begin
            state_d  = ST_RDATA;
            io_oe_d  = 1'b1;
            io_out_d = byte_src[7:4];
            re_d     = 1'b1;
            addr_d   = addr_q + MEM_AW'(1);
            cnt_d    = CNT_W'(1);
          end
        end
        ST_RDATA: begin
          // cnt_q[0] set means the low nibble of the current byte goes out next.
          cnt_d = cnt_q ^ CNT_W'(1);
          if (cnt_q[0]) begin
            io_out_d = buf_q[3:0];
          end else begin
            io_out_d = byte_src[7:4];
            re_d     = 1'b1;
            addr_d   = addr_q + MEM_AW'(1);
          end
        end
        ST_WDATA: begin
          sh_d  = sh_shift;
          cnt_d = cnt_q ^ CNT_W'(1);
          if (we_q) addr_d = addr_q + MEM_AW'(1);
          if (cnt_q[0]) begin
            we_d    = 1'b1;
            wdata_d = cmd_byte;
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign io_out    = io_out_q;
  assign io_oe     = io_oe_q;
  assign mem_addr  = addr_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_qspi_mem_target.sv
// Bench for qspi_mem_target: drives quad frames, models the SRAM, and compares every
// cycle of io/strobe activity against a frame-level reference built from the timing rules.
module tb_qspi_mem_target;
  import qspi_pkg::*;

  localparam int DUMMY  = 4;
  localparam int MEM_AW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cs_n;
  logic [3:0]        io_in;
  logic [3:0]        io_out;
  logic              io_oe;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              mem_we;
  logic [7:0]        mem_wdata;

  int nAssert;
  int nFail;
  int frameNo;

  always #5 clk = ~clk;

  qspi_mem_target #(.PA(24), .MEM_AW(MEM_AW), .DUMMY(DUMMY)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_wdata(mem_wdata)
  );

  // Unwritten locations hold a fixed address-derived pattern.
  function automatic logic [7:0] seedByte(input logic [15:0] a);
    return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'hA7;
  endfunction

  logic [7:0] sram [0:65535];
  bit         sramWr [0:65535];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= sramWr[mem_addr] ? sram[mem_addr] : seedByte(mem_addr);
    if (mem_we) begin
      sram[mem_addr]   <= mem_wdata;
      sramWr[mem_addr] <= 1'b1;
    end
  end

  logic [7:0] refMem [0:65535];
  bit         refWr [0:65535];

  function automatic logic [7:0] refByte(input logic [15:0] a);
    return refWr[a] ? refMem[a] : seedByte(a);
  endfunction

  logic [3:0]  stim     [0:127];
  logic        obsOe    [0:127];
  logic [3:0]  obsOut   [0:127];
  logic        obsRe    [0:127];
  logic        obsWe    [0:127];
  logic [15:0] obsAddr  [0:127];
  logic [7:0]  obsWd    [0:127];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setFrame(input logic [7:0] cmd, input logic [23:0] addr);
    stim[0] = cmd[7:4];
    stim[1] = cmd[3:0];
    for (int i = 0; i < 6; i++) stim[2+i] = addr[23-4*i -: 4];
    for (int k = 8; k < 128; k++) stim[k] = 4'($urandom);
  endtask

  // Edges 0..nLow-1 have cs_n low, edge nLow has it high; obs[c] is the value during cycle c.
  task automatic runFrame(input int nLow, input int rstEdge);
    for (int k = 0; k <= nLow; k++) begin
      cs_n  = (k < nLow) ? 1'b0 : 1'b1;
      io_in = stim[k];
      reset = (k == rstEdge);
      @(posedge clk);
      @(negedge clk);
      obsOe[k+1]   = io_oe;
      obsOut[k+1]  = io_out;
      obsRe[k+1]   = mem_re;
      obsWe[k+1]   = mem_we;
      obsAddr[k+1] = mem_addr;
      obsWd[k+1]   = mem_wdata;
    end
    reset = 1'b0;
  endtask

  task automatic checkFrame(input logic [7:0] cmd, input logic [23:0] addr, input int nLow,
                            input int rstEdge);
    logic [15:0] a;
    bit          isRd;
    bit          isWr;
    a    = addr[15:0];
    isRd = (cmd == 8'hEB);
    isWr = (cmd == 8'h38);
    for (int c = 1; c <= nLow + 1; c++) begin
      bit          live;
      bit          expOe;
      bit          expRe;
      bit          expWe;
      int          n;
      int          m;
      logic [7:0]  b;
      logic [15:0] expA;
      live  = (rstEdge < 0) || (c <= rstEdge);
      expOe = live && isRd && (c >= 8 + DUMMY) && (c <= nLow);
      check($sformatf("f%0d io_oe c%0d", frameNo, c), 32'(obsOe[c]), 32'(expOe));
      if (expOe) begin
        n = c - 8 - DUMMY;
        b = refByte(a + 16'(n / 2));
        check($sformatf("f%0d io_out c%0d", frameNo, c), 32'(obsOut[c]),
              32'((n % 2 == 0) ? b[7:4] : b[3:0]));
      end
      expRe = live && isRd && (c <= nLow) &&
              ((c == 8) || ((c >= 8 + DUMMY) && ((c - 8 - DUMMY) % 2 == 0)));
      check($sformatf("f%0d mem_re c%0d", frameNo, c), 32'(obsRe[c]), 32'(expRe));
      if (expRe) begin
        expA = (c == 8) ? a : a + 16'(1 + (c - 8 - DUMMY) / 2);
        check($sformatf("f%0d re_addr c%0d", frameNo, c), 32'(obsAddr[c]), 32'(expA));
      end
      expWe = live && isWr && (c <= nLow) && (c >= 10) && (c % 2 == 0);
      check($sformatf("f%0d mem_we c%0d", frameNo, c), 32'(obsWe[c]), 32'(expWe));
      if (expWe) begin
        m    = (c - 10) / 2;
        expA = a + 16'(m);
        b    = {stim[8+2*m], stim[9+2*m]};
        check($sformatf("f%0d we_addr c%0d", frameNo, c), 32'(obsAddr[c]), 32'(expA));
        check($sformatf("f%0d we_data c%0d", frameNo, c), 32'(obsWd[c]), 32'(b));
        refMem[expA] = b;
        refWr[expA]  = 1'b1;
      end
      if (rstEdge >= 0 && c == rstEdge + 1) begin
        check($sformatf("f%0d rst io_out c%0d", frameNo, c), 32'(obsOut[c]), 32'(0));
        check($sformatf("f%0d rst addr c%0d", frameNo, c), 32'(obsAddr[c]), 32'(0));
        check($sformatf("f%0d rst wdata c%0d", frameNo, c), 32'(obsWd[c]), 32'(0));
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] addr, input int nLow,
                               input int rstEdge);
    frameNo++;
    runFrame(nLow, rstEdge);
    checkFrame(cmd, addr, nLow, rstEdge);
  endtask

  initial begin
    logic [7:0]  rCmd;
    logic [23:0] rAddr;
    int          rLen;
    int          sel;
    nAssert = 0;
    nFail   = 0;
    frameNo = 0;
    reset   = 1'b1;
    cs_n    = 1'b1;
    io_in   = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset io_oe", 32'(io_oe), 32'(0));
    check("reset io_out", 32'(io_out), 32'(0));
    check("reset mem_re", 32'(mem_re), 32'(0));
    check("reset mem_we", 32'(mem_we), 32'(0));
    check("reset mem_addr", 32'(mem_addr), 32'(0));
    check("reset mem_wdata", 32'(mem_wdata), 32'(0));
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Load 11 22 33 44 at 0x0010 through the write path, then read it back.
    setFrame(8'h38, 24'h000010);
    stim[8] = 4'h1; stim[9]  = 4'h1; stim[10] = 4'h2; stim[11] = 4'h2;
    stim[12] = 4'h3; stim[13] = 4'h3; stim[14] = 4'h4; stim[15] = 4'h4;
    applyStimulus(8'h38, 24'h000010, 16, -1);
    setFrame(8'hEB, 24'h000010);
    applyStimulus(8'hEB, 24'h000010, 19, -1);

    setFrame(8'h38, 24'h000100);
    stim[8] = 4'hA; stim[9] = 4'h5; stim[10] = 4'h5; stim[11] = 4'hA;
    applyStimulus(8'h38, 24'h000100, 12, -1);

    setFrame(8'hEB, 24'h12FFFF);
    applyStimulus(8'hEB, 24'h12FFFF, 16, -1);

    setFrame(8'h9F, 24'h000010);
    applyStimulus(8'h9F, 24'h000010, 22, -1);
    setFrame(8'hEB, 24'h000100);
    applyStimulus(8'hEB, 24'h000100, 20, -1);

    setFrame(8'h38, 24'h000200);
    applyStimulus(8'h38, 24'h000200, 11, -1);
    setFrame(8'hEB, 24'h000200);
    applyStimulus(8'hEB, 24'h000200, 15, -1);

    // Reset during read data, followed by what looks like a fresh read command.
    setFrame(8'hEB, 24'h000010);
    stim[15] = 4'hE; stim[16] = 4'hB;
    applyStimulus(8'hEB, 24'h000010, 30, 14);
    setFrame(8'hEB, 24'h000011);
    applyStimulus(8'hEB, 24'h000011, 18, -1);

    for (int i = 0; i < 14; i++) begin
      sel   = int'($urandom_range(0, 2));
      rCmd  = (sel == 0) ? 8'hEB : (sel == 1) ? 8'h38 : 8'($urandom);
      rAddr = 24'($urandom);
      if (i % 3 == 0) rAddr[15:0] = 16'hFFFE;
      rLen  = int'($urandom_range(2, 40));
      setFrame(rCmd, rAddr);
      applyStimulus(rCmd, rAddr, rLen, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
